// File: rtl/modulo_fsm_controle_pkg.sv
// Shared definitions for the control FSM and the downstream RGB selector:
// state codes, default timing constants and a counter-width helper.
package modulo_fsm_controle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMING  = 2'b01,
    ST_MONITOR = 2'b10,
    ST_HALT    = 2'b11
  } state_t;

  // Defaults sized for a 50 MHz clock
  localparam int unsigned DEF_DEB_CYCLES     = 500000;
  localparam int unsigned DEF_ARM_CYCLES     = 50000000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 150000000;
  localparam int unsigned DEF_CNT_W          = 28;

  // Bits needed for a counter that runs from 0 up to n-1
  function automatic int cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modulo_fsm_controle_if.sv
// Raw inputs and conditioned status outputs of the control FSM.
// The slave side is the FSM itself; the master side drives the raw inputs
// and consumes the state code and flags.
interface modulo_fsm_controle_if;

  logic       bt_in;
  logic       po_in;
  logic [1:0] std;
  logic       bt;
  logic       po;
  logic       at;

  modport master (
    output bt_in,
    output po_in,
    input  std,
    input  bt,
    input  po,
    input  at
  );

  modport slave (
    input  bt_in,
    input  po_in,
    output std,
    output bt,
    output po,
    output at
  );

endinterface

// File: rtl/modulo_debounce.sv
// Two-flop synchroniser followed by a stability counter: the output level
// only follows the synchronised input after it has disagreed with the
// output for DEB_CYCLES consecutive clocks.
module modulo_debounce
  import modulo_fsm_controle_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int DW = cnt_bits(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;

  // Bring the asynchronous input into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Count clocks of disagreement; flip the output once the count is complete
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (sync2 == dout) begin
      cnt <= '0;
    end else if (cnt == DEB_LAST) begin
      dout <= ~dout;
      cnt  <= '0;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

endmodule

// File: rtl/modulo_fsm_controle.sv
// Control FSM feeding the RGB output selector. Conditions the button and
// presence-sensor inputs, sequences IDLE -> ARMING -> MONITOR -> HALT on
// button presses, and raises a sticky alarm when the sensor stays active
// too long in MONITOR. All outputs come straight from flops.
module modulo_fsm_controle
  import modulo_fsm_controle_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = DEF_DEB_CYCLES,
  parameter int unsigned ARM_CYCLES     = DEF_ARM_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  modulo_fsm_controle_if.slave bus
);

  localparam logic [CNT_W-1:0] ARM_LAST     = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             bt_db;
  logic             bt_q;
  logic             press;
  logic             po_s1;
  logic             po_s2;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             at_q;
  logic             at_next;

  modulo_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_bt_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (bus.bt_in),
    .dout  (bt_db)
  );

  // Sensor needs synchronising only; it is not debounced
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      po_s1 <= 1'b0;
      po_s2 <= 1'b0;
    end else begin
      po_s1 <= bus.po_in;
      po_s2 <= po_s1;
    end
  end

  // One-clock press pulse on the rising edge of the debounced button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bt_q  <= 1'b0;
      press <= 1'b0;
    end else begin
      bt_q  <= bt_db;
      press <= bt_db & ~bt_q;
    end
  end

  // State, shared phase counter and alarm flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      at_q  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      at_q  <= at_next;
    end
  end

  // Next state; a press always wins over expiry or timeout in the same cycle
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    at_next    = at_q;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        at_next  = 1'b0;
        if (press) begin
          state_next = ST_ARMING;
        end
      end
      ST_ARMING: begin
        at_next = 1'b0;
        if (press) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == ARM_LAST) begin
          state_next = ST_MONITOR;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_MONITOR: begin
        if (press) begin
          state_next = ST_HALT;
          cnt_next   = '0;
          at_next    = 1'b0;
        end else if (!po_s2) begin
          cnt_next = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          at_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_HALT: begin
        cnt_next = '0;
        at_next  = 1'b0;
        if (press) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        at_next    = 1'b0;
      end
    endcase
  end

  // Outputs are the registers themselves, so there is no decode delay
  always_comb begin
    bus.std = state;
    bus.bt  = bt_db;
    bus.po  = po_s2;
    bus.at  = at_q;
  end

endmodule

// File: tb/tb_modulo_fsm_controle.sv
// Self-checking bench for modulo_fsm_controle with short timing constants.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_modulo_fsm_controle;
  import modulo_fsm_controle_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    logic       bt_in;
    logic       po_in;
    logic [1:0] std;
    logic       bt;
    logic       po;
    logic       at;
  } vec_t;

  vec_t vecs [18];

  modulo_fsm_controle_if bus ();

  modulo_fsm_controle #(
    .DEB_CYCLES     (4),
    .ARM_CYCLES     (8),
    .TIMEOUT_CYCLES (10),
    .CNT_W          (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic b, input logic p);
    bus.bt_in = b;
    bus.po_in = p;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] e_std,
                             input logic e_bt, input logic e_po, input logic e_at);
    n_checks++;
    if (bus.std === e_std && bus.bt === e_bt && bus.po === e_po && bus.at === e_at) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got std=%b bt=%b po=%b at=%b, expected std=%b bt=%b po=%b at=%b",
               name, bus.std, bus.bt, bus.po, bus.at, e_std, e_bt, e_po, e_at);
    end
  endtask

  // Clean press: debounced level rises after 6 edges, the pulse is registered
  // on the 7th, so the FSM reacts on the caller's next edge. The button is
  // let go early enough that another press may start right after that edge.
  task automatic pressButton();
    bus.bt_in = 1'b1;
    repeat (4) tick();
    bus.bt_in = 1'b0;
    repeat (3) tick();
  endtask

  function automatic logic interruptedPo(input int i);
    return (i >= 1 && i <= 7) || (i >= 9 && i <= 15);
  endfunction

  initial begin
    // Bouncing button then a held press, plus a sensor pulse during ARMING
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};

    $display("[TB] start");
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("reset_hold", ST_IDLE, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput($sformatf("idle_%0d", i), ST_IDLE, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].bt_in, vecs[i].po_in);
      tick();
      checkOutput($sformatf("vec_%0d", i), vecs[i].std, vecs[i].bt, vecs[i].po, vecs[i].at);
    end

    // Releasing the button only drops the debounced level; no state change
    applyStimulus(1'b0, 1'b0);
    repeat (5) tick();
    checkOutput("release_hold", ST_MONITOR, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("release_fall", ST_MONITOR, 1'b0, 1'b0, 1'b0);

    // Sensor 7 high, 1 low, 7 high never reaches the timeout
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, interruptedPo(i));
      tick();
      checkOutput($sformatf("interrupted_%0d", i), ST_MONITOR, 1'b0, interruptedPo(i - 1), 1'b0);
    end

    // Press arrives in the same cycle the count reaches its last value
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1);
      tick();
      checkOutput($sformatf("race_po_%0d", i), ST_MONITOR, 1'b0, i >= 2, 1'b0);
    end
    pressButton();
    checkOutput("race_before", ST_MONITOR, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("race_halt", ST_HALT, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("race_halt_1", ST_HALT, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("race_halt_2", ST_HALT, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);

    pressButton();
    tick();
    checkOutput("halt_to_idle", ST_IDLE, 1'b1, 1'b0, 1'b0);

    // Abort: the earliest follow-up press lands on the last ARMING cycle
    pressButton();
    tick();
    checkOutput("arm_1", ST_ARMING, 1'b1, 1'b0, 1'b0);
    pressButton();
    checkOutput("arm_last_cycle", ST_ARMING, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("abort", ST_IDLE, 1'b1, 1'b0, 1'b0);
    pressButton();
    tick();
    checkOutput("rearm", ST_ARMING, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput($sformatf("rearm_%0d", i), (i < 8) ? ST_ARMING : ST_MONITOR, i < 2, 1'b0, 1'b0);
    end

    // Timeout after 10 clocks of sensor activity, then sticky
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b0, 1'b1);
      tick();
      checkOutput($sformatf("timeout_%0d", i), ST_MONITOR, 1'b0, i >= 2, i >= 12);
    end
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b0);
      tick();
      checkOutput($sformatf("sticky_%0d", i), ST_MONITOR, 1'b0, i < 2, 1'b1);
    end
    pressButton();
    checkOutput("sticky_before_press", ST_MONITOR, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("halt_clears_at", ST_HALT, 1'b1, 1'b0, 1'b0);

    // Full cycle 11 -> 00 -> 01 -> 10 -> 11 -> 00
    pressButton();
    tick();
    checkOutput("cycle_idle", ST_IDLE, 1'b1, 1'b0, 1'b0);
    pressButton();
    tick();
    checkOutput("cycle_arming", ST_ARMING, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("cycle_arming_1", ST_ARMING, 1'b1, 1'b0, 1'b0);
    pressButton();
    checkOutput("cycle_monitor", ST_MONITOR, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("cycle_halt", ST_HALT, 1'b1, 1'b0, 1'b0);
    pressButton();
    tick();
    checkOutput("cycle_back_idle", ST_IDLE, 1'b1, 1'b0, 1'b0);

    // Reach MONITOR with the alarm set, then reset between clock edges
    pressButton();
    tick();
    checkOutput("rst_arming", ST_ARMING, 1'b1, 1'b0, 1'b0);
    repeat (8) tick();
    checkOutput("rst_monitor", ST_MONITOR, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    repeat (12) tick();
    checkOutput("rst_alarm", ST_MONITOR, 1'b0, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", ST_IDLE, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("after_reset", ST_IDLE, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
